// File: rtl/me_lsu_wb.sv
// Purpose: memory-stage load/store unit with req/ack data-memory port and MEM/WB pipeline register.
// Latency: 1 cycle for non-memory/misaligned ops; memory ops complete on the mem_ack edge (min 2 cycles).
// Backpressure: stall holds upstream from issue until mem_ack or timeout; flush kills the WB result.
module me_lsu_wb #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] incrementPCIn,
    input  logic [XLEN-1:0] ALUResIn,
    input  logic [XLEN-1:0] RS2In,
    input  logic [4:0]      rdIn,
    input  logic            dm_writeIn,
    input  logic [2:0]      dm_ctrlIn,
    input  logic [1:0]      ru_data_srcIn,
    input  logic            ru_writeIn,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_alu_res,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [XLEN-1:0] wb_pc4,
    output logic [4:0]      wb_rd,
    output logic [1:0]      wb_ru_data_src,
    output logic            wb_ru_write,
    output logic            misaligned,
    output logic            bus_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t          state, stateNext;
    logic [CW-1:0]   waitCnt;

    // Instruction context captured at issue so completion does not depend on upstream holding.
    logic [XLEN-1:0] pendAlu, pendPc4;
    logic [4:0]      pendRd;
    logic [1:0]      pendSrc, pendOff;
    logic [2:0]      pendCtrl;
    logic            pendRuWrite, pendLoad, pendKill;

    logic            memOp, isMisaligned, startReq, passThrough, ackHit, timeoutHit;
    logic [XLEN-1:0] storeData;
    logic [3:0]      storeBe;

    // Decode the incoming bundle: memory-op detection, alignment, store lane steering.
    always_comb begin
        memOp        = in_valid & (dm_writeIn | (ru_data_srcIn == 2'b01));
        isMisaligned = 1'b0;
        storeData    = RS2In;
        storeBe      = 4'b1111;
        case (dm_ctrlIn[1:0])
            2'b00: begin
                storeData = {4{RS2In[7:0]}};
                storeBe   = 4'b0001 << ALUResIn[1:0];
            end
            2'b01: begin
                isMisaligned = ALUResIn[0];
                storeData    = {2{RS2In[15:0]}};
                storeBe      = 4'b0011 << {ALUResIn[1], 1'b0};
            end
            default: begin
                isMisaligned = |ALUResIn[1:0];
            end
        endcase
        // A flushed op is never issued to memory; a misaligned one completes immediately.
        startReq    = (state == IDLE) & memOp & ~isMisaligned & ~flush;
        passThrough = (state == IDLE) & in_valid & ~flush & ~(memOp & ~isMisaligned);
        ackHit      = (state == WAIT_ACK) & mem_ack;
        timeoutHit  = (state == WAIT_ACK) & ~mem_ack & (waitCnt == CW'(TIMEOUT - 1));
    end

    // Next-state and stall: upstream is held from issue until ack or timeout.
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (startReq) begin
                    stateNext = WAIT_ACK;
                    stall     = 1'b1;
                end
            end
            WAIT_ACK: begin
                stall = ~(mem_ack | timeoutHit);
                if (mem_ack || timeoutHit) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] word,
                                                   input logic [1:0] off,
                                                   input logic [2:0] ctrl);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        lane = word >> {off, 3'b000};
        case (ctrl)
            3'b000:  res = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  res = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  res = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  res = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    // Memory port, wait counter and captured context.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            waitCnt     <= '0;
            pendAlu     <= '0;
            pendPc4     <= '0;
            pendRd      <= '0;
            pendSrc     <= '0;
            pendOff     <= '0;
            pendCtrl    <= '0;
            pendRuWrite <= 1'b0;
            pendLoad    <= 1'b0;
            pendKill    <= 1'b0;
        end else begin
            if (startReq) begin
                mem_req     <= 1'b1;
                mem_we      <= dm_writeIn;
                mem_addr    <= {ALUResIn[XLEN-1:2], 2'b00};
                mem_wdata   <= storeData;
                mem_be      <= storeBe;
                waitCnt     <= '0;
                pendAlu     <= ALUResIn;
                pendPc4     <= incrementPCIn;
                pendRd      <= rdIn;
                pendSrc     <= ru_data_srcIn;
                pendOff     <= ALUResIn[1:0];
                pendCtrl    <= dm_ctrlIn;
                pendRuWrite <= ru_writeIn;
                pendLoad    <= ~dm_writeIn;
                pendKill    <= 1'b0;
            end else if (state == WAIT_ACK) begin
                // A flush seen at any point while waiting discards the eventual result.
                if (flush) begin
                    pendKill <= 1'b1;
                end
                if (mem_ack || timeoutHit) begin
                    mem_req <= 1'b0;
                end else begin
                    waitCnt <= waitCnt + CW'(1);
                end
            end
        end
    end

    // MEM/WB register: loads on pass-through or access completion; data fields hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_alu_res     <= '0;
            wb_mem_data    <= '0;
            wb_pc4         <= '0;
            wb_rd          <= '0;
            wb_ru_data_src <= '0;
            wb_ru_write    <= 1'b0;
            misaligned     <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_ru_write <= 1'b0;
            misaligned  <= 1'b0;
            bus_error   <= 1'b0;
            if (passThrough) begin
                wb_valid       <= 1'b1;
                wb_alu_res     <= ALUResIn;
                wb_mem_data    <= '0;
                wb_pc4         <= incrementPCIn;
                wb_rd          <= rdIn;
                wb_ru_data_src <= ru_data_srcIn;
                wb_ru_write    <= ru_writeIn & ~memOp;
                misaligned     <= memOp;
            end else if ((ackHit || timeoutHit) && !pendKill && !flush) begin
                wb_valid       <= 1'b1;
                wb_alu_res     <= pendAlu;
                wb_mem_data    <= (ackHit && pendLoad) ? extendLoad(mem_rdata, pendOff, pendCtrl) : '0;
                wb_pc4         <= pendPc4;
                wb_rd          <= pendRd;
                wb_ru_data_src <= pendSrc;
                wb_ru_write    <= pendRuWrite & ackHit;
                bus_error      <= timeoutHit;
            end
        end
    end

endmodule

// File: tb/tb_me_lsu_wb.sv
// Purpose: directed self-checking bench for me_lsu_wb.
// Latency: checks 1-cycle pass-through and ack-terminated memory accesses.
// Backpressure: counts stall cycles per access, exercises flush, timeout and reset mid-access.
module tb_me_lsu_wb;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush;
    logic [31:0] incrementPCIn, ALUResIn, RS2In;
    logic [4:0]  rdIn;
    logic        dm_writeIn;
    logic [2:0]  dm_ctrlIn;
    logic [1:0]  ru_data_srcIn;
    logic        ru_writeIn;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_alu_res, wb_mem_data, wb_pc4;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_ru_data_src;
    logic        wb_ru_write, misaligned, bus_error;

    int tests = 0;
    int fails = 0;
    int stalls;

    always #5 clk = ~clk;

    me_lsu_wb #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .incrementPCIn(incrementPCIn), .ALUResIn(ALUResIn), .RS2In(RS2In),
        .rdIn(rdIn), .dm_writeIn(dm_writeIn), .dm_ctrlIn(dm_ctrlIn),
        .ru_data_srcIn(ru_data_srcIn), .ru_writeIn(ru_writeIn),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data),
        .wb_pc4(wb_pc4), .wb_rd(wb_rd), .wb_ru_data_src(wb_ru_data_src),
        .wb_ru_write(wb_ru_write), .misaligned(misaligned), .bus_error(bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic setOp(input logic v, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic we,
                         input logic [2:0] ctrl, input logic [1:0] src, input logic ruw);
        in_valid = v; incrementPCIn = pc4; ALUResIn = alu; RS2In = rs2; rdIn = rd;
        dm_writeIn = we; dm_ctrlIn = ctrl; ru_data_srcIn = src; ru_writeIn = ruw;
    endtask

    // Op already driven at this negedge (cycle 0); request appears cycle 1, ack on cycle 1+ackAfter.
    task automatic runMem(input int ackAfter, input logic [31:0] rdata, input logic [31:0] expAddr,
                          input logic expWe, input logic [3:0] expBe, input logic [31:0] expWdata,
                          output int nStall);
        nStall = 0;
        for (int k = 0; k <= ackAfter + 1; k++) begin
            mem_ack   = (k == ackAfter + 1);
            mem_rdata = rdata;
            #1;
            if (stall) nStall++;
            if (k == 1) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_addr", mem_addr, expAddr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, expWe});
                if (expWe) begin
                    chk("mem_be", {28'd0, mem_be}, {28'd0, expBe});
                    chk("mem_wdata", mem_wdata, expWdata);
                end
            end
            cyc();
        end
        in_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        setOp(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'b000, 2'b00, 1'b0);
        cyc(); cyc();
        // Reset state
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem", {26'd0, mem_req, mem_we, mem_be}, 32'd0);
        chk("rst_addr", mem_addr | mem_wdata, 32'd0);
        chk("rst_wb", {21'd0, wb_valid, wb_rd, wb_ru_data_src, wb_ru_write, misaligned, bus_error}, 32'd0);
        chk("rst_wbdata", wb_alu_res | wb_mem_data | wb_pc4, 32'd0);
        rst = 1'b0;
        cyc();

        // ALU op: latency 1, no stall
        setOp(1'b1, 32'h104, 32'h1234, 32'h0, 5'd5, 1'b0, 3'b010, 2'b00, 1'b1);
        #1 chk("alu_stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("alu_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_res", wb_alu_res, 32'h1234);
        chk("alu_rd_pc", {wb_rd, wb_pc4[26:0]}, {5'd5, 27'h104});
        chk("alu_ruw", {29'd0, wb_ru_write, wb_ru_data_src}, 32'b100);
        chk("alu_nomem", {31'd0, mem_req}, 32'd0);
        in_valid = 1'b0;
        cyc();
        chk("idle_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle_hold", wb_alu_res, 32'h1234);

        // LB 0x103, ack one cycle after request
        setOp(1'b1, 32'h200, 32'h103, 32'h0, 5'd6, 1'b0, 3'b000, 2'b01, 1'b1);
        runMem(1, 32'h80FF_0000, 32'h100, 1'b0, 4'b0000, 32'h0, stalls);
        chk("lb_stalls", stalls, 32'd2);
        chk("lb_data", wb_mem_data, 32'hFFFF_FF80);
        chk("lb_wb", {25'd0, wb_valid, wb_rd, wb_ru_write}, {25'd0, 1'b1, 5'd6, 1'b1});
        chk("lb_req_drop", {31'd0, mem_req}, 32'd0);

        // LBU same address
        setOp(1'b1, 32'h204, 32'h103, 32'h0, 5'd7, 1'b0, 3'b100, 2'b01, 1'b1);
        runMem(1, 32'h80FF_0000, 32'h100, 1'b0, 4'b0000, 32'h0, stalls);
        chk("lbu_data", wb_mem_data, 32'h0000_0080);

        // LH 0x102, minimum latency ack
        setOp(1'b1, 32'h208, 32'h102, 32'h0, 5'd8, 1'b0, 3'b001, 2'b01, 1'b1);
        runMem(0, 32'h80FF_0000, 32'h100, 1'b0, 4'b0000, 32'h0, stalls);
        chk("lh_stalls", stalls, 32'd1);
        chk("lh_data", wb_mem_data, 32'hFFFF_80FF);

        // SH 0x102, ack three cycles after request
        setOp(1'b1, 32'h20C, 32'h102, 32'h1234_ABCD, 5'd0, 1'b1, 3'b001, 2'b00, 1'b0);
        runMem(3, 32'hFFFF_FFFF, 32'h100, 1'b1, 4'b1100, 32'hABCD_ABCD, stalls);
        chk("sh_stalls", stalls, 32'd4);
        chk("sh_wb", {30'd0, wb_valid, wb_ru_write}, 32'b10);
        chk("sh_memdata", wb_mem_data, 32'd0);

        // SB 0x102
        setOp(1'b1, 32'h210, 32'h102, 32'h0000_0055, 5'd0, 1'b1, 3'b000, 2'b00, 1'b0);
        runMem(0, 32'h0, 32'h100, 1'b1, 4'b0100, 32'h5555_5555, stalls);
        chk("sb_valid", {31'd0, wb_valid}, 32'd1);

        // LW misaligned: no request, one-cycle pass with error
        setOp(1'b1, 32'h214, 32'h101, 32'h0, 5'd9, 1'b0, 3'b010, 2'b01, 1'b1);
        #1 chk("mis_stall", {31'd0, stall}, 32'd0);
        cyc();
        in_valid = 1'b0;
        chk("mis_flags", {28'd0, wb_valid, misaligned, wb_ru_write, mem_req}, 32'b1100);
        cyc();
        chk("mis_pulse", {31'd0, misaligned}, 32'd0);

        // LW with no ack: timeout after 16 WAIT cycles
        setOp(1'b1, 32'h218, 32'h300, 32'h0, 5'd10, 1'b0, 3'b010, 2'b01, 1'b1);
        #1 chk("to_stall0", {31'd0, stall}, 32'd1);
        cyc();
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("to_stall%0d", k), {31'd0, stall}, (k == 16) ? 32'd0 : 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        chk("to_err", {28'd0, wb_valid, bus_error, wb_ru_write, mem_req}, 32'b1100);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        cyc();
        mem_ack = 1'b0;
        chk("late_ack", {28'd0, wb_valid, bus_error, mem_req, stall}, 32'd0);

        // Flush while waiting: transaction completes, result dropped
        setOp(1'b1, 32'h21C, 32'h400, 32'h0, 5'd11, 1'b0, 3'b010, 2'b01, 1'b1);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1 chk("fl_stall", {31'd0, stall}, 32'd0);
        cyc();
        mem_ack = 1'b0; in_valid = 1'b0;
        chk("fl_wb", {29'd0, wb_valid, wb_ru_write, mem_req}, 32'd0);

        // Reset during WAIT
        setOp(1'b1, 32'h220, 32'h500, 32'hDEAD_BEEF, 5'd0, 1'b1, 3'b010, 2'b00, 1'b0);
        cyc();
        chk("rw_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        cyc();
        #1;
        chk("rw_mem", {25'd0, stall, mem_req, mem_we, mem_be}, 32'd0);
        chk("rw_addr", mem_addr | mem_wdata, 32'd0);
        chk("rw_wb", {21'd0, wb_valid, wb_rd, wb_ru_data_src, wb_ru_write, misaligned, bus_error}, 32'd0);
        chk("rw_wbdata", wb_alu_res | wb_mem_data | wb_pc4, 32'd0);
        rst = 1'b0;
        cyc();
        chk("rw_idle", {30'd0, mem_req, wb_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
